// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - four-requester round-robin arbiter with grant hold
//
// Shares one resource among four requesters. The scan starts just after the
// last owner, so no requester can starve. A grant is held until its owner
// drops its request. Every grant is followed by at least one idle cycle.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   When defined, an owner that has held the grant for MAX_HOLD cycles is
//   forced off if another requester is waiting. The forced release is
//   flagged by a one-cycle timeout pulse.
//
// Ports:
//   clock    in   1  system clock, rising edge
//   reset_n  in   1  asynchronous active-low reset
//   request  in   4  per-requester request, held for the whole transaction
//   grant    out  4  registered one-hot grant, zero when idle
//   valid    out  1  OR of grant
//   user     out  2  index of the granted requester, zero when idle
//   timeout  out  1  one-cycle pulse on forced release (0 without macro)

module rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] request,
  output logic [NUM_REQ-1:0] grant,
  output logic               valid,
  output logic [1:0]         user,
  output logic               timeout
);

  // Elaboration-time parameter checks: the index width and the 8-bit hold
  // counter only cover these ranges.
  if (NUM_REQ != 4) begin : g_bad_num_req
    $error("rr_arbiter: NUM_REQ must be 4");
  end
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arbiter: MAX_HOLD must be in 1..255");
  end

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [NUM_REQ-1:0] ONE_HOT_0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [1:0]         user_q,  user_d;
  logic [1:0]         last_q,  last_d;
  logic               valid_q, valid_d;

  // Rotating priority scan result
  logic               scan_found;
  logic [1:0]         scan_winner;
  logic [1:0]         scan_idx;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

  logic [7:0] hold_q, hold_d;
  logic       timeout_q, timeout_d;
  logic       others_waiting;
`endif

  // Scan last+1 .. last+4 (mod 4); the 2-bit add wraps naturally. The owner
  // of the previous grant is therefore looked at last.
  always_comb begin
    scan_found  = 1'b0;
    scan_winner = 2'd0;
    scan_idx    = 2'd0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      scan_idx = last_q + 2'(i);
      if (!scan_found && request[scan_idx]) begin
        scan_found  = 1'b1;
        scan_winner = scan_idx;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Anyone other than the current owner asking for the resource
  assign others_waiting = |(request & ~grant_q);
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    user_d  = user_q;
    last_d  = last_q;
`ifdef ARB_TIMEOUT_EN
    hold_d    = hold_q;
    timeout_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (scan_found) begin
          state_d = BUSY;
          grant_d = ONE_HOT_0 << scan_winner;
          user_d  = scan_winner;
`ifdef ARB_TIMEOUT_EN
          hold_d  = 8'd1;
`endif
        end
      end

      BUSY: begin
        if (!request[user_q]) begin
          // Owner finished: release and remember it as the lowest priority.
          // Arbitration among the other requesters waits for the next edge.
          state_d = IDLE;
          grant_d = '0;
          user_d  = 2'd0;
          last_d  = user_q;
`ifdef ARB_TIMEOUT_EN
          hold_d  = 8'd0;
`endif
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_q == MAX_HOLD_C && others_waiting) begin
          // Forced release; the owner rejoins the scan as lowest priority.
          state_d   = IDLE;
          grant_d   = '0;
          user_d    = 2'd0;
          last_d    = user_q;
          hold_d    = 8'd0;
          timeout_d = 1'b1;
        end
        else if (hold_q != 8'hff) begin
          hold_d = hold_q + 8'd1;
        end
`endif
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
        user_d  = 2'd0;
      end
    endcase

    valid_d = |grant_d;
  end

  // State and output registers; last resets to 3 so requester 0 wins first.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      user_q  <= 2'd0;
      last_q  <= 2'd3;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      user_q  <= user_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_q    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign grant = grant_q;
  assign valid = valid_q;
  assign user  = user_q;

endmodule

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
- Four-requester round-robin arbiter with grant hold, sharing one resource (bus, memory port, UART) between requesters.
- Scans from the index after the last granted requester, so no requester starves.
- Holds a one-hot grant until the owner drops its request.
- Sits between requester masters and the shared datapath mux; `user` drives the mux select directly.

Parameters:
- NUM_REQ, 4, number of requesters. Fixed at 4; `user` width is 2.
- MAX_HOLD, 16, maximum consecutive grant cycles before forced release. Legal range 1..255. Used only with ARB_TIMEOUT_EN.

Ports:
- clock  input  1  system clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- request  input  4  per-requester request; held high for the whole transaction
- grant  output  4  one-hot grant, registered; all zero when idle
- valid  output  1  high when any grant is asserted; equals OR of grant
- user  output  2  index of granted requester; 0 when idle
- timeout  output  1  one-cycle pulse on forced release; constant 0 without ARB_TIMEOUT_EN

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; grant = 0; valid = 0; user = 0.
  - Pointer last = 3, so requester 0 has top priority first.
  - Hold counter = 0.
- States:
  - IDLE: no owner.
  - BUSY: owner = user.
- Registers: all outputs registered; no combinational path from request to grant.
- IDLE, request == 0: stay in IDLE.
- IDLE, request != 0:
  - Scan indices (last+1), (last+2), (last+3), (last+4) mod 4. The first set bit wins.
  - At that edge: grant = one-hot(winner), user = winner, valid = 1, state -> BUSY, hold counter = 1.
  - Latency: request seen high at edge k gives grant high after edge k.
- BUSY, request[user] == 1:
  - grant, user and valid hold.
  - Hold counter increments, saturating at 255.
  - Other requests are ignored; no preemption.
- BUSY, request[user] == 0:
  - At that edge: grant = 0, valid = 0, user = 0, last = old user, state -> IDLE.
  - Mandatory turnaround: at least one IDLE cycle between consecutive grants. Back-to-back grants to different requesters are never adjacent.
- Simultaneous events:
  - The owner drops its request while others raise theirs in the same cycle: release happens first. Arbitration occurs on the next edge from IDLE with the updated last.
- Requests in the same cycle as reset deassertion are sampled on the first clock after release.
- Requester drops before its grant arrives: the grant still issues for at least one cycle. It releases on the following edge because request[user] == 0.
- Invariants, checked by the bench:
  - grant is one-hot or zero.
  - valid == |grant.
  - user == index of set grant bit.
  - grant never asserted while in IDLE.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined: in BUSY, if hold counter == MAX_HOLD and any other request bit is high, the arbiter force-releases at that edge:
  - grant = 0, last = owner, state -> IDLE.
  - timeout pulses high for exactly one cycle, coincident with grant dropping.
  - An owner still requesting rejoins arbitration at the lowest priority.
  - If no other requester is waiting, the owner keeps the grant past MAX_HOLD; the counter saturates and no timeout fires.
- Undefined: no forced release; timeout tied to 0; counter may be optimised away.

Test Plan:
- Reset then request = 4'b0101 held → after 1 edge grant = 4'b0001, user = 0. Drop request[0] → grant = 0 for 1 cycle, then grant = 4'b0100, user = 2.
- All four requesters high; each drops its request 3 cycles after its grant, then re-raises it → grant order 0, 1, 2, 3, 0, with exactly one idle cycle between grants.
- Owner 1 holds 40 cycles while request = 4'b1011 → grant stays 4'b0010 the whole time (macro off). Next grant goes to 3, then 0.
- ARB_TIMEOUT_EN, MAX_HOLD = 4: requester 2 owns, requester 0 requesting → grant 4'b0100 for exactly 4 cycles, timeout pulse, 1 idle cycle, then grant = 4'b0001.
- Assert reset_n low mid-BUSY, asynchronously between edges → grant, valid and user go 0 immediately. After release with request = 4'b1000 → grant = 4'b1000 with last = 3 restored (0 scanned first).
- Single-cycle request pulse on requester 3 → grant = 4'b1000 for 1 cycle, then 0. The invariants hold on random request streams of 10k cycles.
